fetch_stage: RTL



---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_skid.sv | 46 ++++
 rtl/fetch_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Types and constants shared between the fetch stage, its skid buffer and decode.
package fetch_stage_pkg;

  localparam int          XLEN   = 64;
  localparam int          ILEN   = 32;
  localparam logic [63:0] PCINIT = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] raw_instr;
  } fetch_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic            data_ok;
    logic [ILEN-1:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {FETCH, HOLD, KILL} fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} buffer that catches a response arriving while decode stalls.
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  fetch_data_t load_data,
  input  logic        drain,
  input  logic        clear,
  output logic        valid,
  output fetch_data_t data
);

  logic        valid_q, valid_d;
  fetch_data_t data_q, data_d;

  // Clear (redirect) beats load so a killed response can never linger here.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with F/D register: owns the PC, drives a hold-until-data_ok
// request, absorbs decode stalls in a skid entry and discards killed responses.
module fetch_stage #(
  parameter logic [63:0] PCINIT = fetch_stage_pkg::PCINIT,
  parameter int          ILEN   = fetch_stage_pkg::ILEN
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         ireq_valid,
  output logic [63:0]                  ireq_addr,
  input  logic                         iresp_data_ok,
  input  logic [ILEN-1:0]              iresp_data,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [63:0]                  redirect_pc,
  output fetch_stage_pkg::fetch_data_t dataF,
  output logic                         validF
);
  import fetch_stage_pkg::*;

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  ibus_req_t    req_q, req_d;
  ibus_resp_t   resp;
  fetch_data_t  data_q, data_d;
  logic         valid_q, valid_d;
  logic         done;
  logic         skid_load, skid_drain, skid_clear, skid_valid;
  fetch_data_t  skid_in, skid_out;

  assign resp    = '{data_ok: iresp_data_ok, data: iresp_data};
  assign done    = req_q.valid && resp.data_ok;
  assign skid_in = '{pc: req_q.addr, raw_instr: resp.data};

  fetch_skid u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (skid_load),
    .load_data(skid_in),
    .drain    (skid_drain),
    .clear    (skid_clear),
    .valid    (skid_valid),
    .data     (skid_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (req_q.valid && !resp.data_ok) ? KILL : FETCH;
    end else begin
      case (state_q)
        FETCH:   if (done && stall) state_d = HOLD;
        HOLD:    if (!stall)        state_d = FETCH;
        KILL:    if (done)          state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    pc_d       = pc_q;
    req_d      = req_q;
    data_d     = data_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
    if (redirect_valid) begin
      // An uncompleted request stays on the bus (KILL); otherwise the bus idles
      // for one cycle and the target is issued from pc next.
      pc_d       = redirect_pc;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      if (done || !req_q.valid) req_d.valid = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q.valid) begin
            req_d = '{valid: 1'b1, addr: pc_q};
            if (!stall) valid_d = 1'b0;
          end else if (done) begin
            req_d.valid = 1'b0;
            pc_d        = pc_q + 64'd4;
            if (stall) begin
              skid_load = 1'b1;
            end else begin
              data_d  = skid_in;
              valid_d = 1'b1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            data_d     = skid_out;
            valid_d    = skid_valid;
            skid_drain = 1'b1;
          end
        end
        KILL: begin
          valid_d = 1'b0;
          if (done) req_d.valid = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= PCINIT;
      req_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      req_q   <= req_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign ireq_valid = req_q.valid;
  assign ireq_addr  = req_q.addr;
  assign dataF      = data_q;
  assign validF     = valid_q;

endmodule
